// File: rtl/rcpu_pkg.sv
// Shared definitions for the single-step R-type CPU controller.
// Contains the funct field constants, the 4-bit ALU op codes and the FSM state encoding.
// It also provides the decode helper that maps an instruction word to {legal, op}.
package rcpu_pkg;

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADDU = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SUBU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    typedef struct packed {
        logic    legal;
        alu_op_e op;
    } dec_t;

    // Only opcode 0 with one of the ten supported funct codes is legal.
    // Illegal words decode to ALU_ADD so the operand path stays well defined.
    function automatic dec_t decode_rtype(input logic [31:0] inst);
        dec_t d;
        d.legal = (inst[31:26] == OPCODE_RTYPE);
        d.op    = ALU_ADD;
        case (inst[5:0])
            FUNCT_ADD:  d.op = ALU_ADD;
            FUNCT_ADDU: d.op = ALU_ADDU;
            FUNCT_SUB:  d.op = ALU_SUB;
            FUNCT_SUBU: d.op = ALU_SUBU;
            FUNCT_AND:  d.op = ALU_AND;
            FUNCT_OR:   d.op = ALU_OR;
            FUNCT_XOR:  d.op = ALU_XOR;
            FUNCT_NOR:  d.op = ALU_NOR;
            FUNCT_SLT:  d.op = ALU_SLT;
            FUNCT_SLTU: d.op = ALU_SLTU;
            default:    d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rcpu_debounce.sv
// Step button conditioner: 2-flop synchroniser, stability counter, rising-edge pulse.
// Latency: 2 sync cycles + DEB_CYCLES stable samples + 1 cycle to the registered pulse.
// No backpressure: the pulse is one cycle wide and the consumer either takes it or drops it.
module rcpu_debounce #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic step_o
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q;

    // The level flips only after DEB_CYCLES consecutive samples disagree with it;
    // any sample that agrees restarts the count, so bounces shorter than that are lost.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, debounced level, counter and the 0->1 pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            step_q  <= level_d & ~level_q;
        end
    end

    assign step_o = step_q;

endmodule

// File: rtl/rcpu_step_ctrl.sv
// Single-step R-type controller: each debounced press runs fetch, decode, exec, write-back.
// Latency: step request in cycle N -> regfile write pulse in N+4 -> display outputs in N+5.
// Backpressure: none; step requests arriving while busy are dropped, never queued.
module rcpu_step_ctrl
    import rcpu_pkg::*;
#(
    parameter int unsigned PC_W       = 5,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic            RCPU_STEP_clk_xi,
    input  logic            RCPU_STEP_rst_xi,
    input  logic            RCPU_STEP_step_xi,
    output logic [PC_W-1:0] RCPU_STEP_pc_xo,
    input  logic [31:0]     RCPU_STEP_inst_xi,
    output logic [4:0]      RCPU_STEP_ra_xo,
    output logic [4:0]      RCPU_STEP_rb_xo,
    input  logic [31:0]     RCPU_STEP_a_xi,
    input  logic [31:0]     RCPU_STEP_b_xi,
    output logic [31:0]     RCPU_STEP_alu_a_xo,
    output logic [31:0]     RCPU_STEP_alu_b_xo,
    output logic [3:0]      RCPU_STEP_alu_op_xo,
    input  logic [31:0]     RCPU_STEP_alu_f_xi,
    input  logic            RCPU_STEP_alu_of_xi,
    input  logic            RCPU_STEP_alu_zf_xi,
    output logic            RCPU_STEP_we_xo,
    output logic [4:0]      RCPU_STEP_wa_xo,
    output logic [31:0]     RCPU_STEP_wd_xo,
    output logic [31:0]     RCPU_STEP_data_xo,
    output logic            RCPU_STEP_of_xo,
    output logic            RCPU_STEP_zf_xo,
    output logic            RCPU_STEP_busy_xo,
    output logic            RCPU_STEP_illegal_xo
);

    state_e          state_q, state_d;
    logic            step_req;
    dec_t            dec;
    logic [31:0]     ir_q;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     alu_a_q, alu_b_q;
    alu_op_e         alu_op_q;
    logic            legal_q;
    logic [31:0]     f_q;
    logic            f_of_q, f_zf_q;
    logic            we_q;
    logic [4:0]      wa_q;
    logic [31:0]     data_q;
    logic            of_q, zf_q;
    logic            illegal_q;
    logic            is_addsub;
    logic            unused_shamt;

    rcpu_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk_i  (RCPU_STEP_clk_xi),
        .rst_i  (RCPU_STEP_rst_xi),
        .btn_i  (RCPU_STEP_step_xi),
        .step_o (step_req)
    );

    // State register.
    always_ff @(posedge RCPU_STEP_clk_xi) begin
        if (RCPU_STEP_rst_xi) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fixed one-cycle-per-phase sequence; a request is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (step_req) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign dec          = decode_rtype(ir_q);
    assign is_addsub    = (alu_op_q == ALU_ADD) || (alu_op_q == ALU_SUB);
    // The shift-amount field has no meaning for the supported ops.
    assign unused_shamt = ^ir_q[10:6];

    // Per-phase datapath: IR, operand latches, result capture, write-back and display hold.
    always_ff @(posedge RCPU_STEP_clk_xi) begin
        if (RCPU_STEP_rst_xi) begin
            ir_q      <= '0;
            pc_q      <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= ALU_ADD;
            legal_q   <= 1'b0;
            f_q       <= '0;
            f_of_q    <= 1'b0;
            f_zf_q    <= 1'b0;
            we_q      <= 1'b0;
            wa_q      <= '0;
            data_q    <= '0;
            of_q      <= 1'b0;
            zf_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_FETCH: begin
                    ir_q <= RCPU_STEP_inst_xi;
                end
                ST_DECODE: begin
                    alu_a_q  <= RCPU_STEP_a_xi;
                    alu_b_q  <= RCPU_STEP_b_xi;
                    alu_op_q <= dec.op;
                    legal_q  <= dec.legal;
                end
                ST_EXEC: begin
                    // Write-back data/address are set up here so the pulse lands in WB;
                    // an illegal word leaves the previous result untouched.
                    if (legal_q) begin
                        f_q    <= RCPU_STEP_alu_f_xi;
                        f_of_q <= RCPU_STEP_alu_of_xi & is_addsub;
                        f_zf_q <= RCPU_STEP_alu_zf_xi;
                        wa_q   <= ir_q[15:11];
                        we_q   <= (ir_q[15:11] != 5'd0);
                    end
                end
                ST_WB: begin
                    if (legal_q) begin
                        data_q <= f_q;
                        of_q   <= f_of_q;
                        zf_q   <= f_zf_q;
                    end else begin
                        illegal_q <= 1'b1;
                    end
                    pc_q <= pc_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign RCPU_STEP_pc_xo      = pc_q;
    assign RCPU_STEP_ra_xo      = ir_q[25:21];
    assign RCPU_STEP_rb_xo      = ir_q[20:16];
    assign RCPU_STEP_alu_a_xo   = alu_a_q;
    assign RCPU_STEP_alu_b_xo   = alu_b_q;
    assign RCPU_STEP_alu_op_xo  = alu_op_q;
    // Reset arriving during WB must still suppress the regfile write in that same cycle.
    assign RCPU_STEP_we_xo      = we_q & ~RCPU_STEP_rst_xi;
    assign RCPU_STEP_wa_xo      = wa_q;
    assign RCPU_STEP_wd_xo      = f_q;
    assign RCPU_STEP_data_xo    = data_q;
    assign RCPU_STEP_of_xo      = of_q;
    assign RCPU_STEP_zf_xo      = zf_q;
    assign RCPU_STEP_busy_xo    = (state_q != ST_IDLE);
    assign RCPU_STEP_illegal_xo = illegal_q;

endmodule

// File: tb/tb_rcpu_step_ctrl.sv
// Bench for rcpu_step_ctrl: models ROM, regfile and ALU around the DUT and
// predicts each step's outcome from the instruction semantics.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_rcpu_step_ctrl;
    import rcpu_pkg::*;

    localparam int PC_W = 2;
    localparam int DEB  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            step = 1'b0;
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
    logic [4:0]      ra, rb, wa;
    logic [31:0]     a, b, alu_a, alu_b, alu_f, wd, data;
    logic [3:0]      alu_op;
    logic            alu_of, alu_zf, we, of, zf, busy, illegal;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rcpu_step_ctrl #(.PC_W(PC_W), .DEB_CYCLES(DEB)) dut (
        .RCPU_STEP_clk_xi     (clk),
        .RCPU_STEP_rst_xi     (rst),
        .RCPU_STEP_step_xi    (step),
        .RCPU_STEP_pc_xo      (pc),
        .RCPU_STEP_inst_xi    (inst),
        .RCPU_STEP_ra_xo      (ra),
        .RCPU_STEP_rb_xo      (rb),
        .RCPU_STEP_a_xi       (a),
        .RCPU_STEP_b_xi       (b),
        .RCPU_STEP_alu_a_xo   (alu_a),
        .RCPU_STEP_alu_b_xo   (alu_b),
        .RCPU_STEP_alu_op_xo  (alu_op),
        .RCPU_STEP_alu_f_xi   (alu_f),
        .RCPU_STEP_alu_of_xi  (alu_of),
        .RCPU_STEP_alu_zf_xi  (alu_zf),
        .RCPU_STEP_we_xo      (we),
        .RCPU_STEP_wa_xo      (wa),
        .RCPU_STEP_wd_xo      (wd),
        .RCPU_STEP_data_xo    (data),
        .RCPU_STEP_of_xo      (of),
        .RCPU_STEP_zf_xo      (zf),
        .RCPU_STEP_busy_xo    (busy),
        .RCPU_STEP_illegal_xo (illegal)
    );

    // ---------------- environment: ROM, regfile, ALU ----------------
    logic [31:0] rom  [4];
    logic [31:0] regs [32];

    always_comb inst = rom[pc];
    always_comb a    = regs[ra];
    always_comb b    = regs[rb];

    // The ALU reports signed overflow for the unsigned add/sub too, so the
    // controller's masking of that flag is actually exercised.
    always_comb begin
        alu_f  = 32'h0;
        alu_of = 1'b0;
        case (alu_op)
            ALU_ADD, ALU_ADDU: begin
                alu_f  = alu_a + alu_b;
                alu_of = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            ALU_SUB, ALU_SUBU: begin
                alu_f  = alu_a - alu_b;
                alu_of = (alu_a[31] != alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            ALU_AND:  alu_f = alu_a & alu_b;
            ALU_OR:   alu_f = alu_a | alu_b;
            ALU_XOR:  alu_f = alu_a ^ alu_b;
            ALU_NOR:  alu_f = ~(alu_a | alu_b);
            ALU_SLT:  alu_f = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_f = {31'd0, alu_a < alu_b};
            default:  alu_f = 32'hDEAD_BEEF;
        endcase
        alu_zf = (alu_f == 32'h0);
    end

    always @(posedge clk) begin
        if (we === 1'b1 && wa != 5'd0) regs[wa] = wd;
    end

    // ---------------- monitor ----------------
    int          cyc = 0, we_cnt = 0, we_cyc = -1, busy_rise_cyc = -1;
    logic        busy_prev = 1'b0, we_prev = 1'b0;
    logic [4:0]  obs_wa = '0;
    logic [31:0] obs_wd = '0, data_after_we = '0;

    always @(negedge clk) begin
        cyc++;
        if (busy === 1'b1 && busy_prev !== 1'b1) busy_rise_cyc = cyc;
        if (we_prev) data_after_we = data;
        if (we === 1'b1) begin
            we_cnt++;
            we_cyc = cyc;
            obs_wa = wa;
            obs_wd = wd;
        end
        busy_prev = busy;
        we_prev   = (we === 1'b1);
    end

    // ---------------- reference model ----------------
    logic [PC_W-1:0] exp_pc = '0;
    logic [31:0]     exp_data = '0, exp_wd = '0;
    logic [4:0]      exp_wa = '0;
    logic            exp_of = 1'b0, exp_zf = 1'b0, exp_illegal = 1'b0;
    int              exp_we_n = 0;

    // {legal, overflow, result} straight from the MIPS R-type definitions.
    function automatic logic [33:0] ref_exec(input logic [31:0] ins,
                                             input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic        o, l;
        r = 32'h0;
        o = 1'b0;
        l = (ins[31:26] == 6'd0);
        case (ins[5:0])
            6'h20: begin r = x + y; o = (x[31] == y[31]) && (r[31] != x[31]); end
            6'h21: r = x + y;
            6'h22: begin r = x - y; o = (x[31] != y[31]) && (r[31] != x[31]); end
            6'h23: r = x - y;
            6'h24: r = x & y;
            6'h25: r = x | y;
            6'h26: r = x ^ y;
            6'h27: r = ~(x | y);
            6'h2A: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            6'h2B: r = (x < y) ? 32'd1 : 32'd0;
            default: l = 1'b0;
        endcase
        if (!l) begin r = 32'h0; o = 1'b0; end
        return {l, o, r};
    endfunction

    function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    task automatic model_step(input logic [31:0] ins);
        logic [33:0] r;
        rom[exp_pc] = ins;
        r = ref_exec(ins, regs[ins[25:21]], regs[ins[20:16]]);
        exp_we_n = (r[33] && ins[15:11] != 5'd0) ? 1 : 0;
        exp_wa   = ins[15:11];
        exp_wd   = r[31:0];
        if (r[33]) begin
            exp_data = r[31:0];
            exp_of   = r[32];
            exp_zf   = (r[31:0] == 32'h0);
        end else begin
            exp_illegal = 1'b1;
        end
        exp_pc = exp_pc + 1'b1;
    endtask

    task automatic model_reset();
        exp_pc = '0; exp_data = '0; exp_of = 1'b0; exp_zf = 1'b0; exp_illegal = 1'b0;
    endtask

    task automatic clear_obs();
        we_cnt = 0; we_cyc = -1; busy_rise_cyc = -1; data_after_we = '0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int hold);
        step = 1'b1;
        settle(hold);
        step = 1'b0;
    endtask

    task automatic run_step(input logic [31:0] ins, input int hold);
        model_step(ins);
        clear_obs();
        press(hold);
        settle(30);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        settle(3);
        tests_run++;
        if ({pc, ra, rb, alu_a, alu_b, alu_op, we, wa, wd, data, of, zf, busy, illegal} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: pc=%0d ra=%0d rb=%0d alu_a=%h alu_b=%h op=%0d we=%b wa=%0d wd=%h data=%h of=%b zf=%b busy=%b ill=%b, required all zero",
                     pc, ra, rb, alu_a, alu_b, alu_op, we, wa, wd, data, of, zf, busy, illegal);
        end
        clear_obs();
        press(15);
        settle(4);
        rst = 1'b0;
        settle(25);
        tests_run++;
        if (we_cnt != 0 || busy !== 1'b0 || pc !== '0) begin
            tests_failed++;
            $display("FAIL press_in_reset: we_cnt=%0d busy=%b pc=%0d, required 0/0/0", we_cnt, busy, pc);
        end
        model_reset();
    endtask

    task automatic test_add();
        regs[1] = 32'd7; regs[2] = 32'd5;
        run_step(mk_r(1, 2, 3, 6'h20), 12);
        tests_run++;
        if (we_cnt != 1 || obs_wa !== 5'd3 || obs_wd !== 32'd12 || regs[3] !== 32'd12) begin
            tests_failed++;
            $display("FAIL add_writeback: we_cnt=%0d wa=%0d wd=%h reg3=%h, required 1/3/0000000c/0000000c",
                     we_cnt, obs_wa, obs_wd, regs[3]);
        end
        tests_run++;
        if (data !== 32'd12 || of !== 1'b0 || zf !== 1'b0 || pc !== 2'd1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_display: data=%h of=%b zf=%b pc=%0d busy=%b, required 0000000c/0/0/1/0",
                     data, of, zf, pc, busy);
        end
        tests_run++;
        if (we_cyc - busy_rise_cyc != 3 || data_after_we !== 32'd12) begin
            tests_failed++;
            $display("FAIL add_latency: busy->we=%0d data_next=%h, required 3/0000000c",
                     we_cyc - busy_rise_cyc, data_after_we);
        end
    endtask

    task automatic test_sub_zero();
        regs[1] = 32'd9;
        run_step(mk_r(1, 1, 4, 6'h22), 12);
        tests_run++;
        if (we_cnt != 1 || obs_wa !== 5'd4 || data !== 32'd0 || zf !== 1'b1 || of !== 1'b0 || pc !== exp_pc) begin
            tests_failed++;
            $display("FAIL sub_zero: we_cnt=%0d wa=%0d data=%h zf=%b of=%b pc=%0d, required 1/4/0/1/0/%0d",
                     we_cnt, obs_wa, data, zf, of, pc, exp_pc);
        end
    endtask

    task automatic test_overflow();
        regs[5] = 32'h7FFF_FFFF; regs[6] = 32'd1;
        run_step(mk_r(5, 6, 7, 6'h20), 12);
        tests_run++;
        if (we_cnt != 1 || obs_wd !== 32'h8000_0000 || data !== 32'h8000_0000 || of !== 1'b1 || regs[7] !== 32'h8000_0000) begin
            tests_failed++;
            $display("FAIL add_overflow: we_cnt=%0d wd=%h data=%h of=%b reg7=%h, required 1/80000000/80000000/1/80000000",
                     we_cnt, obs_wd, data, of, regs[7]);
        end
        run_step(mk_r(5, 6, 8, 6'h21), 12);
        tests_run++;
        if (we_cnt != 1 || data !== 32'h8000_0000 || of !== 1'b0 || regs[8] !== 32'h8000_0000) begin
            tests_failed++;
            $display("FAIL addu_no_of: we_cnt=%0d data=%h of=%b reg8=%h, required 1/80000000/0/80000000",
                     we_cnt, data, of, regs[8]);
        end
    endtask

    task automatic test_rd_zero();
        regs[1] = 32'd3; regs[2] = 32'd4;
        run_step(mk_r(1, 2, 0, 6'h25), 12);
        tests_run++;
        if (we_cnt != 0 || data !== 32'd7 || regs[0] !== 32'd0 || pc !== exp_pc) begin
            tests_failed++;
            $display("FAIL rd_zero: we_cnt=%0d data=%h reg0=%h pc=%0d, required 0/00000007/0/%0d",
                     we_cnt, data, regs[0], pc, exp_pc);
        end
    endtask

    task automatic test_bounce();
        logic [31:0] d0;
        d0 = data;
        clear_obs();
        for (int i = 0; i < 10; i++) begin
            step = (i % 4) < 2;
            settle(1);
        end
        step = 1'b0;
        settle(30);
        tests_run++;
        if (we_cnt != 0 || busy_rise_cyc != -1 || pc !== exp_pc || data !== d0) begin
            tests_failed++;
            $display("FAIL bounce: we_cnt=%0d busy_seen=%0d pc=%0d data=%h, required 0/-1/%0d/%h",
                     we_cnt, busy_rise_cyc, pc, data, exp_pc, d0);
        end
    endtask

    task automatic test_hold();
        regs[9] = 32'hF0F0_1234; regs[10] = 32'h0FF0_4321;
        run_step(mk_r(9, 10, 11, 6'h26), 100);
        tests_run++;
        if (we_cnt != 1 || obs_wd !== 32'hFF00_5115 || data !== 32'hFF00_5115 || pc !== exp_pc) begin
            tests_failed++;
            $display("FAIL hold_100: we_cnt=%0d wd=%h data=%h pc=%0d, required 1/ff005115/ff005115/%0d",
                     we_cnt, obs_wd, data, pc, exp_pc);
        end
    endtask

    task automatic test_busy_repress();
        regs[12] = 32'd100; regs[13] = 32'd30;
        model_step(mk_r(12, 13, 14, 6'h23));
        clear_obs();
        step = 1'b1;
        for (int i = 0; i < 40 && busy !== 1'b1; i++) settle(1);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_wait: busy=%b after 40 cycles, required 1", busy);
        end
        step = 1'b0;
        settle(1);
        step = 1'b1;
        settle(20);
        step = 1'b0;
        settle(30);
        tests_run++;
        if (we_cnt != 1 || data !== 32'd70 || pc !== exp_pc) begin
            tests_failed++;
            $display("FAIL repress_busy: we_cnt=%0d data=%h pc=%0d, required 1/00000046/%0d",
                     we_cnt, data, pc, exp_pc);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] d0;
        d0 = data;
        run_step({6'h08, 5'd1, 5'd9, 16'h0004}, 12);
        tests_run++;
        if (we_cnt != 0 || data !== d0 || illegal !== 1'b1 || pc !== exp_pc) begin
            tests_failed++;
            $display("FAIL illegal_opcode: we_cnt=%0d data=%h ill=%b pc=%0d, required 0/%h/1/%0d",
                     we_cnt, data, illegal, pc, d0, exp_pc);
        end
    endtask

    task automatic test_random();
        logic [5:0]  fn_tab [10];
        logic [31:0] ins;
        int          rs, rt, rd;
        fn_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        for (int it = 0; it < 20; it++) begin
            rs = $urandom_range(0, 31);
            rt = $urandom_range(0, 31);
            rd = $urandom_range(0, 31);
            if (rs != 0) regs[rs] = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
            if (rt != 0) regs[rt] = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            ins = mk_r(rs, rt, rd, fn_tab[$urandom_range(0, 9)]);
            if ($urandom_range(0, 7) == 0) ins[31:26] = 6'($urandom_range(1, 63));
            if ($urandom_range(0, 7) == 0) ins[5:0]   = 6'h00;
            run_step(ins, $urandom_range(10, 30));
            tests_run++;
            if (we_cnt != exp_we_n || data !== exp_data || of !== exp_of || zf !== exp_zf ||
                pc !== exp_pc || illegal !== exp_illegal || busy !== 1'b0 ||
                (exp_we_n == 1 && (obs_wa !== exp_wa || obs_wd !== exp_wd || regs[exp_wa] !== exp_wd))) begin
                tests_failed++;
                $display("FAIL random_%0d ins=%h: we_cnt=%0d wa=%0d wd=%h data=%h of=%b zf=%b pc=%0d ill=%b busy=%b, required we_cnt=%0d wa=%0d wd=%h data=%h of=%b zf=%b pc=%0d ill=%b busy=0",
                         it, ins, we_cnt, obs_wa, obs_wd, data, of, zf, pc, illegal, busy,
                         exp_we_n, exp_wa, exp_wd, exp_data, exp_of, exp_zf, exp_pc, exp_illegal);
            end
        end
    endtask

    // Reset lands in the given phase (2 = EXEC, 3 = WB, counted from FETCH).
    task automatic test_reset_mid(input int phase);
        regs[20] = 32'd11; regs[21] = 32'd22; regs[22] = 32'h5A5A_5A5A;
        model_step(mk_r(20, 21, 22, 6'h20));
        clear_obs();
        step = 1'b1;
        for (int i = 0; i < 40 && busy !== 1'b1; i++) settle(1);
        step = 1'b0;
        settle(phase);
        rst = 1'b1;
        settle(2);
        rst = 1'b0;
        settle(20);
        model_reset();
        tests_run++;
        if (busy_rise_cyc == -1 || we_cnt != 0 || regs[22] !== 32'h5A5A_5A5A || pc !== '0 || busy !== 1'b0 || data !== '0) begin
            tests_failed++;
            $display("FAIL reset_phase%0d: busy_seen=%0d we_cnt=%0d reg22=%h pc=%0d busy=%b data=%h, required seen/0/5a5a5a5a/0/0/0",
                     phase, busy_rise_cyc, we_cnt, regs[22], pc, busy, data);
        end
    endtask

    task automatic test_pc_wrap();
        logic [PC_W-1:0] want;
        rst = 1'b1;
        settle(2);
        rst = 1'b0;
        settle(2);
        model_reset();
        for (int i = 0; i < 4; i++) begin
            regs[1] = 32'(i);
            run_step(mk_r(1, 1, 2, 6'h21), 12);
            want = PC_W'(i + 1);
            tests_run++;
            if (pc !== want || data !== 32'(2 * i)) begin
                tests_failed++;
                $display("FAIL pc_wrap_%0d: pc=%0d data=%h, required %0d/%h", i, pc, data, want, 32'(2 * i));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        for (int i = 0; i < 4; i++)  rom[i]  = 32'h0;
        test_reset();
        test_add();
        test_sub_zero();
        test_overflow();
        test_rd_zero();
        test_bounce();
        test_hold();
        test_busy_repress();
        test_illegal();
        test_random();
        test_reset_mid(2);
        test_reset_mid(3);
        test_pc_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
